// File: rtl/topo_spawner.sv
// rtl/topo_spawner.sv - whack-a-mole round sequencer: spawns moles, scores hits/timeouts
// Optional feature macro: SPEEDUP_EN (each scored hit shortens the mole window)
module topo_spawner #(
    parameter int          UP_TICKS   = 50_000_000,
    parameter int          GAP_TICKS  = 25_000_000,
    parameter int          MAX_ROUNDS = 20,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          UP_STEP    = 5_000_000,
    parameter int          UP_MIN     = 10_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       hit,
    output logic       poner_topo,
    output logic [3:0] n_celda_poner_topo,
    output logic       mole_active,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round_cnt,
    output logic       game_over
);

    localparam int T_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] W_UP       = TW'(UP_TICKS);
    localparam logic [TW-1:0] W_GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] W_STEP     = TW'(UP_STEP);
    localparam logic [TW-1:0] W_MIN      = TW'(UP_MIN);
    localparam logic [TW-1:0] W_ONE      = TW'(1);
    localparam logic [7:0]    W_ROUNDS   = 8'(MAX_ROUNDS);

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_WAIT_HIT,
        S_COOLDOWN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_lfsr;
    logic            w_fb;
    logic [3:0]      r_last_cell;
    logic [3:0]      w_raw;
    logic [3:0]      w_cell;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   r_window;
    logic [TW-1:0]   w_window_dec;
    logic [7:0]      r_score;
    logic [7:0]      r_misses;
    logic [7:0]      r_rounds;
    logic            w_timer_zero;
    logic            w_start_game;

    assign w_fb         = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_raw        = r_lfsr[3:0];
    assign w_cell       = (w_raw == r_last_cell) ? w_raw + 4'd1 : w_raw;
    assign w_timer_zero = (r_timer == '0);
    assign w_start_game = start && (r_state == S_IDLE || r_state == S_DONE);
    // Window never drops below W_MIN, so the subtraction below cannot underflow
    assign w_window_dec = ((r_window - W_MIN) >= W_STEP) ? (r_window - W_STEP) : W_MIN;

    assign score     = r_score;
    assign misses    = r_misses;
    assign round_cnt = r_rounds;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_lfsr == 16'd0) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next             = r_state;
        poner_topo         = 1'b0;
        mole_active        = 1'b0;
        game_over          = 1'b0;
        n_celda_poner_topo = r_last_cell;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SPAWN;
            end
            S_SPAWN: begin
                poner_topo         = 1'b1;
                n_celda_poner_topo = w_cell;
                w_next             = S_WAIT_HIT;
            end
            S_WAIT_HIT: begin
                mole_active = 1'b1;
                if (hit || w_timer_zero) w_next = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (w_timer_zero) w_next = (r_rounds == W_ROUNDS) ? S_DONE : S_SPAWN;
            end
            S_DONE: begin
                game_over = 1'b1;
                if (start) w_next = S_SPAWN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_cell <= 4'd0;
            r_timer     <= '0;
            r_window    <= W_UP;
            r_score     <= 8'd0;
            r_misses    <= 8'd0;
            r_rounds    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_game) begin
                        r_score  <= 8'd0;
                        r_misses <= 8'd0;
                        r_rounds <= 8'd0;
                        r_window <= W_UP;
                    end
                end
                S_SPAWN: begin
                    r_last_cell <= w_cell;
                    r_timer     <= r_window - W_ONE;
                end
                S_WAIT_HIT: begin
                    // A hit on the final window cycle takes priority over the timeout
                    if (hit) begin
                        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                        if (SPEEDUP) r_window <= w_window_dec;
                        r_timer  <= W_GAP_LAST;
                        r_rounds <= r_rounds + 8'd1;
                    end else if (w_timer_zero) begin
                        if (r_misses != 8'hFF) r_misses <= r_misses + 8'd1;
                        r_timer  <= W_GAP_LAST;
                        r_rounds <= r_rounds + 8'd1;
                    end else begin
                        r_timer <= r_timer - W_ONE;
                    end
                end
                S_COOLDOWN: begin
                    if (!w_timer_zero) r_timer <= r_timer - W_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
